trng_sample_ctrl: RTL and testbench
===================================

TRNG_SAMPLE_CTRL -- requirements
Module: trng_sample_ctrl

Interface
REQ-001 Parameter WARMUP_CYCLES, default 16: number of cycles the oscillator runs before the first sample (minimum 1).
REQ-002 Parameter SAMPLE_DIV, default 4: number of clk cycles per raw sample (minimum 2).
REQ-003 Parameter REP_LIMIT, default 8: count of consecutive identical raw samples that declares a health failure (range 2..15).
REQ-004 clk  input  1  sole clock; all state is updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  block enable; low forces IDLE.
REQ-007 start  input  1  level request to generate bytes; sampled in IDLE and at each HOLD handshake.
REQ-008 raw_bit  input  1  asynchronous entropy bit from the ring oscillator; passes through a 2-flop synchronizer before any use.
REQ-009 osc_en  output  1  oscillator enable.
REQ-010 byte_out  output  8  assembled random byte; valid while byte_valid is high.
REQ-011 byte_valid  output  1  byte available.
REQ-012 byte_ready  input  1  consumer accepts the byte; a transfer occurs on a cycle with byte_valid and byte_ready both high.
REQ-013 busy  output  1  high in every state except IDLE and FAIL.
REQ-014 health_fail  output  1  sticky health-test failure flag.

Function
REQ-015 States: IDLE, WARMUP, SAMPLE, HOLD, FAIL; the state is encoded in a single registered variable.
REQ-016 IDLE: osc_en=0; on ena=1 and start=1, the next state is WARMUP and the warmup counter is loaded with WARMUP_CYCLES-1.
REQ-017 WARMUP: osc_en=1; the counter decrements each cycle; at 0 the next state is SAMPLE and the divider is cleared. WARMUP therefore lasts exactly WARMUP_CYCLES cycles.
REQ-018 SAMPLE: osc_en=1; the divider counts 0..SAMPLE_DIV-1; on the cycle it equals SAMPLE_DIV-1, the synchronized bit is taken as one raw sample and the divider wraps to 0.
REQ-019 Each accepted bit shifts into byte_out MSB-first (byte_out <= {byte_out[6:0], bit}); a 3-bit counter tracks accepted bits.
REQ-020 On the 8th accepted bit, the next state is HOLD, byte_valid=1, and the bit counter is cleared.
REQ-021 HOLD: osc_en=1; no sampling occurs; byte_out and byte_valid are held until the transfer cycle.
REQ-022 On the transfer cycle, byte_valid drops next cycle; the next state is SAMPLE if start=1, else IDLE. WARMUP is not repeated.
REQ-023 Health test: a 4-bit repetition counter runs on raw samples (before debiasing); a sample equal to the previous one increments it, and a differing sample resets it to 1.
REQ-024 When the repetition counter reaches REP_LIMIT, the next state is FAIL. In FAIL: health_fail=1, osc_en=0, byte_valid=0, and the partial byte is discarded.
REQ-025 Simultaneous events: the health failure takes priority over byte completion on the same sample.
REQ-026 The repetition history clears on entry to WARMUP.
REQ-027 FAIL is exited only by rst_n; ena and start are ignored in FAIL.
REQ-028 If ena=0 in WARMUP, SAMPLE or HOLD, the next state is IDLE: the partial byte and bit counter are cleared, byte_valid=0 and osc_en=0 next cycle.

Reset
REQ-029 On asynchronous assertion of rst_n=0, all of the following take these values immediately:
- state=IDLE
- osc_en=0, byte_valid=0, byte_out=0x00
- busy=0, health_fail=0
- all counters, synchronizer flops and repetition history = 0
REQ-030 Reset deassertion takes effect at the next rising edge of clk; there is no internal reset synchronizer (it is provided at the top level).

Configuration
REQ-031 Macro TRNG_VN_DEBIAS_EN defined: a von Neumann debiaser sits between the raw samples and the shift register.
- Raw samples pair up as (first, second).
- Pair 10 yields bit 1; pair 01 yields bit 0; pairs 00 and 11 are discarded.
- The pair state clears on entry to WARMUP or IDLE.
REQ-032 Macro TRNG_VN_DEBIAS_EN undefined: every raw sample is an accepted bit. The debiaser logic is absent.
REQ-033 The health test is identical in both builds.

Verification
All scenarios use default parameters; raw_bit is held stable for each full sample period.
REQ-034 Start timing: start=1 at cycle 0 -> osc_en rises at cycle 1, and the first raw sample is taken at cycle 1+16+3=20.
REQ-035 Alternating raw samples 1,0,1,0,..., byte_ready=1:
- VN build: byte_out=0xFF, with byte_valid after 16 samples.
- Non-VN build: byte_out=0xAA after 8 samples.
REQ-036 byte_ready=0 for 50 cycles after byte_valid -> byte_out is stable and no samples are taken (divider frozen). Releasing ready with start=0 -> IDLE next cycle, osc_en=0.
REQ-037 Constant raw_bit=1 (non-VN build) -> FAIL on the 8th sample, health_fail=1, byte_valid never asserts; it stays in FAIL with ena toggled, and clears only on rst_n.
REQ-038 ena=0 after 5 accepted bits -> IDLE next cycle; a restart with 8 samples of pattern 0x3C yields exactly byte_out=0x3C (no stale bits).
REQ-039 rst_n asserted mid-SAMPLE, between clock edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/trng_sample_ctrl.sv
// ----------------------------------------------------------------------------
// trng_sample_ctrl
//
// Sampling controller for a ring-oscillator TRNG. Enables the oscillator,
// waits a warm-up period, then takes one raw sample every SAMPLE_DIV clocks
// from a 2-flop synchronised copy of raw_bit. Samples are assembled MSB-first
// into bytes that are offered on a valid/ready handshake. A repetition-count
// health test on the raw samples latches a sticky failure. Only rst_n can
// clear that failure.
//
// Optional feature: define TRNG_VN_DEBIAS_EN to insert a von Neumann debiaser
// between the raw samples and the shift register. A raw pair 10 gives a 1,
// a pair 01 gives a 0, and pairs 00/11 are dropped. The health test always
// sees the raw samples.
//
// Parameters
//   WARMUP_CYCLES  oscillator run time before the first sample (>= 1)
//   SAMPLE_DIV     clk cycles per raw sample (>= 2)
//   REP_LIMIT      identical consecutive raw samples that trip the test (2..15)
//
// Ports
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   ena          in   block enable; low returns to IDLE (except from FAIL)
//   start        in   level request for bytes
//   raw_bit      in   asynchronous entropy bit
//   osc_en       out  oscillator enable
//   byte_out     out  assembled byte, valid while byte_valid is high
//   byte_valid   out  byte available
//   byte_ready   in   consumer accepts byte (transfer = valid & ready)
//   busy         out  high outside IDLE and FAIL
//   health_fail  out  sticky health-test failure
// ----------------------------------------------------------------------------
module trng_sample_ctrl #(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned SAMPLE_DIV    = 4,
  parameter int unsigned REP_LIMIT     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       raw_bit,
  output logic       osc_en,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       busy,
  output logic       health_fail
);

  localparam int unsigned WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int unsigned DVW = $clog2(SAMPLE_DIV);
  localparam logic [WCW-1:0] WARM_LOAD = WCW'(WARMUP_CYCLES - 1);
  localparam logic [DVW-1:0] DIV_LAST  = DVW'(SAMPLE_DIV - 1);
  localparam logic [3:0]     REP_LIM   = 4'(REP_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_SAMPLE,
    ST_HOLD,
    ST_FAIL
  } state_t;

  state_t         state_q;
  logic           sync1_q;
  logic           sync2_q;
  logic [WCW-1:0] warm_cnt_q;
  logic [DVW-1:0] div_q;
  logic [2:0]     bit_cnt_q;
  logic [7:0]     shift_q;
  logic           valid_q;
  logic           osc_en_q;
  logic           busy_q;
  logic           fail_q;
  logic [3:0]     rep_cnt_q;
  logic           rep_prev_q;
`ifdef TRNG_VN_DEBIAS_EN
  logic           pair_have_q;
  logic           pair_first_q;
`endif

  logic           sample_tick;
  logic [3:0]     rep_cnt_d;
  logic           rep_hit;
  logic           bit_accept;
  logic           bit_value;
  logic           byte_done;
  logic           run_state;

  always_comb begin
    run_state   = (state_q == ST_WARMUP) || (state_q == ST_SAMPLE) || (state_q == ST_HOLD);
    sample_tick = (state_q == ST_SAMPLE) && (div_q == DIV_LAST);
    // After a history clear, prev=0/cnt=0 makes the first sample count 1
    // whichever value it has.
    rep_cnt_d   = (sync2_q == rep_prev_q) ? rep_cnt_q + 4'd1 : 4'd1;
    rep_hit     = (rep_cnt_d == REP_LIM);
`ifdef TRNG_VN_DEBIAS_EN
    bit_accept  = pair_have_q && (pair_first_q != sync2_q);
    bit_value   = pair_first_q;
`else
    bit_accept  = 1'b1;
    bit_value   = sync2_q;
`endif
    byte_done   = bit_accept && (bit_cnt_q == 3'd7);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      warm_cnt_q   <= '0;
      div_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      valid_q      <= 1'b0;
      osc_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      fail_q       <= 1'b0;
      rep_cnt_q    <= '0;
      rep_prev_q   <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
      pair_have_q  <= 1'b0;
      pair_first_q <= 1'b0;
`endif
    end else begin
      sync1_q <= raw_bit;
      sync2_q <= sync1_q;

      if (run_state && !ena) begin
        state_q      <= ST_IDLE;
        shift_q      <= '0;
        bit_cnt_q    <= '0;
        valid_q      <= 1'b0;
        osc_en_q     <= 1'b0;
        busy_q       <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
        pair_have_q  <= 1'b0;
        pair_first_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ena && start) begin
              state_q      <= ST_WARMUP;
              warm_cnt_q   <= WARM_LOAD;
              rep_cnt_q    <= '0;
              rep_prev_q   <= 1'b0;
              osc_en_q     <= 1'b1;
              busy_q       <= 1'b1;
`ifdef TRNG_VN_DEBIAS_EN
              pair_have_q  <= 1'b0;
              pair_first_q <= 1'b0;
`endif
            end
          end

          ST_WARMUP: begin
            if (warm_cnt_q == '0) begin
              state_q <= ST_SAMPLE;
              div_q   <= '0;
            end else begin
              warm_cnt_q <= warm_cnt_q - WCW'(1);
            end
          end

          ST_SAMPLE: begin
            if (sample_tick) begin
              div_q      <= '0;
              rep_cnt_q  <= rep_cnt_d;
              rep_prev_q <= sync2_q;
`ifdef TRNG_VN_DEBIAS_EN
              pair_have_q  <= ~pair_have_q;
              pair_first_q <= sync2_q;
`endif
              // Health failure wins over a byte completing on the same sample.
              if (rep_hit) begin
                state_q   <= ST_FAIL;
                fail_q    <= 1'b1;
                osc_en_q  <= 1'b0;
                busy_q    <= 1'b0;
                valid_q   <= 1'b0;
                shift_q   <= '0;
                bit_cnt_q <= '0;
              end else if (bit_accept) begin
                shift_q <= {shift_q[6:0], bit_value};
                if (byte_done) begin
                  bit_cnt_q <= '0;
                  valid_q   <= 1'b1;
                  state_q   <= ST_HOLD;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                end
              end
            end else begin
              div_q <= div_q + DVW'(1);
            end
          end

          ST_HOLD: begin
            // The divider is already 0 here, so sampling resumes on a full period.
            if (byte_ready) begin
              valid_q <= 1'b0;
              if (start) begin
                state_q <= ST_SAMPLE;
              end else begin
                state_q  <= ST_IDLE;
                osc_en_q <= 1'b0;
                busy_q   <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
                pair_have_q  <= 1'b0;
                pair_first_q <= 1'b0;
`endif
              end
            end
          end

          ST_FAIL: begin
            state_q <= ST_FAIL;
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign osc_en      = osc_en_q;
  assign byte_out    = shift_q;
  assign byte_valid  = valid_q;
  assign busy        = busy_q;
  assign health_fail = fail_q;

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// ----------------------------------------------------------------------------
// tb_trng_sample_ctrl
//
// Scoreboard bench for trng_sample_ctrl at default parameters. The driver
// produces raw samples, one per sample period, and predicts each byte from
// the sample sequence. In the debiased build it uses pair rules. It pushes
// the predicted byte into a queue. A separate monitor pops the queue and
// compares on every handshake. Directed checks cover reset, start timing,
// holding, the health failure, an abort/restart and an asynchronous reset.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trng_sample_ctrl;

  localparam int unsigned WARM = 16;
  localparam int unsigned SDIV = 4;
  localparam int unsigned RLIM = 8;
`ifdef TRNG_VN_DEBIAS_EN
  localparam logic [7:0] ALT_BYTE = 8'hFF;
`else
  localparam logic [7:0] ALT_BYTE = 8'hAA;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       raw_bit;
  logic       osc_en;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;
  logic       health_fail;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_q[$];
  int unsigned gap;
  int unsigned run_len;
  logic        last_raw;

  trng_sample_ctrl #(
    .WARMUP_CYCLES(WARM),
    .SAMPLE_DIV   (SDIV),
    .REP_LIMIT    (RLIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .raw_bit    (raw_bit),
    .osc_en     (osc_en),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens on the coming edge when valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && byte_valid === 1'b1 && byte_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", byte_out, $time);
        end else begin
          chk("byte", byte_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Present one raw sample for a full period. Random samples are steered away
  // from reaching the repetition limit. The model tracks the run length since
  // WARMUP was entered.
  task automatic drive_sample(input logic b_in, input bit avoid, output logic b);
    b = b_in;
    if (avoid && run_len == RLIM - 1 && b == last_raw) b = ~b;
    if (run_len == 0 || b != last_raw) run_len = 1;
    else run_len++;
    last_raw = b;
    raw_bit  = b;
    repeat (gap) @(negedge clk);
    gap = SDIV;
  endtask

  task automatic gen_bits(input bit rnd, input logic [7:0] pat, input int unsigned nbits,
                          output logic [7:0] acc);
    logic a;
`ifdef TRNG_VN_DEBIAS_EN
    logic c;
`endif
    int unsigned got = 0;
    acc = '0;
    while (got < nbits) begin
`ifdef TRNG_VN_DEBIAS_EN
      if (rnd) begin
        drive_sample(1'($urandom), 1'b1, a);
        drive_sample(1'($urandom), 1'b1, c);
      end else begin
        drive_sample(pat[3'(7 - got)], 1'b0, a);
        drive_sample(~pat[3'(7 - got)], 1'b0, c);
      end
      if (a != c) begin
        acc = {acc[6:0], a};
        got++;
      end
`else
      if (rnd) drive_sample(1'($urandom), 1'b1, a);
      else     drive_sample(pat[3'(7 - got)], 1'b0, a);
      acc = {acc[6:0], a};
      got++;
`endif
    end
  endtask

  task automatic start_session();
    ena     = 1'b1;
    start   = 1'b1;
    run_len = 0;
    @(negedge clk);
    chk("osc_en_start", osc_en, 1);
    chk("busy_start", busy, 1);
    gap = WARM + SDIV;
  endtask

  task automatic byte_complete(input bit rnd, input logic [7:0] pat, output logic [7:0] acc);
    gen_bits(rnd, pat, 8, acc);
    exp_q.push_back(acc);
    chk("valid_rise", byte_valid, 1);
  endtask

  task automatic release_byte(input int unsigned hold, input bit nstart);
    repeat (hold) begin
      @(negedge clk);
      raw_bit = 1'($urandom);
    end
    byte_ready = 1'b1;
    start      = nstart;
    @(negedge clk);
    byte_ready = 1'b0;
    chk("valid_drop", byte_valid, 0);
    if (!nstart) begin
      chk("idle_osc", osc_en, 0);
      chk("idle_busy", busy, 0);
    end
    gap = SDIV;
  endtask

  initial begin
    logic [7:0]  acc;
    logic        a;
    int unsigned nb;

    rst_n      = 1'b0;
    ena        = 1'b0;
    start      = 1'b0;
    raw_bit    = 1'b0;
    byte_ready = 1'b0;
    gap        = SDIV;
    run_len    = 0;
    last_raw   = 1'b0;

    #12;
    chk("rst_osc", osc_en, 0);
    chk("rst_valid", byte_valid, 0);
    chk("rst_byte", byte_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fail", health_fail, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Alternating raw samples, then a long stall with the consumer not ready.
    start_session();
    byte_complete(1'b0, ALT_BYTE, acc);
    chk("alt_byte", byte_out, ALT_BYTE);
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      raw_bit = 1'($urandom);
      chk("hold_stable", {byte_valid, byte_out}, {1'b1, ALT_BYTE});
    end
    release_byte(0, 1'b0);

    // Random sessions with random stalls; sampling must resume on a full period.
    for (int unsigned s = 0; s < 4; s++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_session();
      nb = $urandom_range(2, 5);
      for (int unsigned b = 0; b < nb; b++) begin
        byte_complete(1'b1, 8'h00, acc);
        release_byte($urandom_range(0, 8), (b + 1) < nb);
      end
    end

    // Abort after 5 accepted bits, then restart with a known pattern.
    start_session();
    gen_bits(1'b1, 8'h00, 5, acc);
    ena   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("abort_osc", osc_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", byte_valid, 0);
    repeat (3) @(negedge clk);
    start_session();
    byte_complete(1'b0, 8'h3C, acc);
    chk("restart_byte", byte_out, 8'h3C);
    release_byte(1, 1'b0);

    // Constant raw 1: the 8th sample trips the health test and no byte appears.
    byte_ready = 1'b1;
    start_session();
    for (int unsigned i = 0; i < 7; i++) drive_sample(1'b1, 1'b0, a);
    chk("no_fail_yet", health_fail, 0);
    drive_sample(1'b1, 1'b0, a);
    chk("fail_flag", health_fail, 1);
    chk("fail_osc", osc_en, 0);
    chk("fail_busy", busy, 0);
    chk("fail_valid", byte_valid, 0);
    chk("fail_byte", byte_out, 0);
    for (int unsigned i = 0; i < 12; i++) begin
      ena   = 1'($urandom);
      start = 1'($urandom);
      @(negedge clk);
      chk("fail_sticky", {health_fail, osc_en, busy}, 3'b100);
    end
    byte_ready = 1'b0;
    ena        = 1'b0;
    start      = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("fail_cleared", health_fail, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset between clock edges in the middle of sampling.
    start_session();
    gen_bits(1'b1, 8'h00, 3, acc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {osc_en, byte_valid, byte_out, busy, health_fail}, 12'h000);
    ena   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
